wbu_buf: RTL and testbench
==========================

WBU_BUF -- requirements
Module: wbu_buf

Interface
REQ-001 SHALL have parameter CPU_WIDTH, default 64, data width (32 or 64 only).
REQ-002 SHALL have parameter REG_ADDRW, default 5, register index width.
REQ-003 SHALL have parameter DEPTH, default 2, writeback buffer entries (1..8).
REQ-004 SHALL have port i_clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port i_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port i_pre_valid  in  1  LSU result valid.
REQ-007 SHALL have port o_pre_ready  out  1  buffer can accept.
REQ-008 SHALL have port i_lsu_exres  in  CPU_WIDTH  execute result.
REQ-009 SHALL have port i_lsu_lsres  in  CPU_WIDTH  raw load data, right-aligned.
REQ-010 SHALL have port i_lsu_ldfmt  in  3  load format, funct3 encoding.
REQ-011 SHALL have ports i_lsu_rdid (REG_ADDRW), i_lsu_rdwen (1), i_lsu_lden (1)  in  destination, write enable, load select.
REQ-012 SHALL have port s_lsu_diffpc  in  CPU_WIDTH  sim PC.
REQ-013 SHALL have port o_wbu_valid  out  1  head entry present.
REQ-014 SHALL have port i_wbu_ready  in  1  regfile port free.
REQ-015 SHALL have ports o_wbu_rdwen (1), o_wbu_rd (CPU_WIDTH), o_wbu_rdid (REG_ADDRW)  out  regfile write.
REQ-016 SHALL have ports i_rs1id, i_rs2id  in  REG_ADDRW  forwarding lookup.
REQ-017 SHALL have ports o_rs1_hit, o_rs2_hit (1), o_rs1_fwd, o_rs2_fwd (CPU_WIDTH)  out  forwarding result.
REQ-018 SHALL have port o_retire_cnt  out  64  retired-instruction count.
REQ-019 SHALL have port s_wbu_diffpc  out  CPU_WIDTH  head entry PC.

Function
REQ-020 SHALL hold up to DEPTH entries in FIFO order {rd value, rdid, rdwen, diffpc}.
REQ-021 SHALL compute rd value at enqueue: lden=0 -> exres; lden=1 -> lsres extended per ldfmt.
REQ-022 SHALL extend: 000 sign byte, 001 sign half, 010 sign word, 011 full 64-bit, 100 zero byte, 101 zero half, 110 zero word; 111 and 011 in 32-bit mode pass data unchanged.
REQ-023 SHALL assert o_pre_ready = (count < DEPTH) | pop; push = i_pre_valid & o_pre_ready.
REQ-024 SHALL assert o_wbu_valid = (count != 0); pop = o_wbu_valid & i_wbu_ready.
REQ-025 SHALL drive o_wbu_rd, o_wbu_rdid, s_wbu_diffpc from head entry combinationally.
REQ-026 SHALL drive o_wbu_rdwen = pop & head.rdwen & (head.rdid != 0).
REQ-027 SHALL make a pushed entry visible at head the cycle after push when empty (latency 1, no same-cycle bypass to output).
REQ-028 SHALL support simultaneous push and pop at any count, including full; count unchanged.
REQ-029 SHALL hold head entry and outputs stable while o_wbu_valid & !i_wbu_ready.
REQ-030 SHALL wrap read/write pointers modulo DEPTH; non-power-of-two DEPTH supported.
REQ-031 SHALL set o_rsN_hit when any valid entry has rdwen=1, rdid=i_rsNid, rdid!=0; o_rsN_fwd = youngest such entry value, else 0.
REQ-032 SHALL exclude the entry being popped this cycle from no lookup (popped entry still forwards in that cycle).
REQ-033 SHALL increment o_retire_cnt by 1 on every pop regardless of rdwen; wrap at 2^64.
REQ-034 SHALL ignore i_lsu_* data when push=0.

Reset
REQ-035 SHALL on i_rst_n low, asynchronously clear count, pointers, o_retire_cnt, all entry storage to 0.
REQ-036 SHALL during reset drive o_wbu_valid=0, o_wbu_rdwen=0, o_wbu_rd=0, o_wbu_rdid=0, hits=0, fwd=0, o_pre_ready=1.
REQ-037 SHALL discard all buffered entries on reset mid-operation; first push after release behaves as from empty.

Verification
REQ-038 SHALL cover: lden=1, ldfmt=000, lsres=0x80 -> o_wbu_rd=0xFFFF_FFFF_FFFF_FF80; ldfmt=100 -> 0x80; ldfmt=110, lsres=0x8000_0000 -> 0x0000_0000_8000_0000.
REQ-039 SHALL cover: DEPTH=2, i_wbu_ready=0, three pushes -> two accepted, o_pre_ready=0 on third, head=first entry stable.
REQ-040 SHALL cover: full buffer, i_pre_valid=1, i_wbu_ready=1 -> push and pop same cycle, count stays 2, order preserved.
REQ-041 SHALL cover: two entries rdid=5 values 0x11 then 0x22, i_rs1id=5 -> o_rs1_hit=1, o_rs1_fwd=0x22; rdid=0 entry -> hit=0, o_wbu_rdwen=0.
REQ-042 SHALL cover: 10 pops with mixed rdwen -> o_retire_cnt=10; reset asserted with 2 entries -> o_wbu_valid=0, count 0, counter 0.

Source files
------------

// File: rtl/wbu_buf.sv
// Writeback buffer between LSU and register file: FIFO of completed results with
// load-data extension at enqueue, youngest-match operand forwarding and a retire counter.
module wbu_buf #(
  parameter int unsigned CPU_WIDTH = 64,
  parameter int unsigned REG_ADDRW = 5,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_pre_valid,
  output logic                 o_pre_ready,
  input  logic [CPU_WIDTH-1:0] i_lsu_exres,
  input  logic [CPU_WIDTH-1:0] i_lsu_lsres,
  input  logic [2:0]           i_lsu_ldfmt,
  input  logic [REG_ADDRW-1:0] i_lsu_rdid,
  input  logic                 i_lsu_rdwen,
  input  logic                 i_lsu_lden,
  input  logic [CPU_WIDTH-1:0] s_lsu_diffpc,
  output logic                 o_wbu_valid,
  input  logic                 i_wbu_ready,
  output logic                 o_wbu_rdwen,
  output logic [CPU_WIDTH-1:0] o_wbu_rd,
  output logic [REG_ADDRW-1:0] o_wbu_rdid,
  input  logic [REG_ADDRW-1:0] i_rs1id,
  input  logic [REG_ADDRW-1:0] i_rs2id,
  output logic                 o_rs1_hit,
  output logic                 o_rs2_hit,
  output logic [CPU_WIDTH-1:0] o_rs1_fwd,
  output logic [CPU_WIDTH-1:0] o_rs2_fwd,
  output logic [63:0]          o_retire_cnt,
  output logic [CPU_WIDTH-1:0] s_wbu_diffpc
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  logic [CPU_WIDTH-1:0] val_q  [DEPTH];
  logic [CPU_WIDTH-1:0] val_d  [DEPTH];
  logic [REG_ADDRW-1:0] rdid_q [DEPTH];
  logic [REG_ADDRW-1:0] rdid_d [DEPTH];
  logic [CPU_WIDTH-1:0] pc_q   [DEPTH];
  logic [CPU_WIDTH-1:0] pc_d   [DEPTH];
  logic [DEPTH-1:0]     rdwen_q, rdwen_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [63:0]          retire_q, retire_d;

  logic                 push, pop;
  logic [63:0]          ls64, ext64;
  logic [CPU_WIDTH-1:0] enq_val;

  assign o_wbu_valid  = (count_q != '0);
  assign pop          = o_wbu_valid & i_wbu_ready;
  assign o_pre_ready  = (count_q < DEPTH_C) | pop;
  assign push         = i_pre_valid & o_pre_ready;

  assign o_wbu_rd     = val_q[rd_ptr_q];
  assign o_wbu_rdid   = rdid_q[rd_ptr_q];
  assign s_wbu_diffpc = pc_q[rd_ptr_q];
  assign o_wbu_rdwen  = pop & rdwen_q[rd_ptr_q] & (rdid_q[rd_ptr_q] != '0);
  assign o_retire_cnt = retire_q;

  // Extension is done at 64 bits and truncated, so word formats degrade to
  // pass-through in 32-bit mode without a separate code path.
  always_comb begin
    ls64 = 64'(i_lsu_lsres);
    case (i_lsu_ldfmt)
      3'b000:  ext64 = {{56{ls64[7]}},  ls64[7:0]};
      3'b001:  ext64 = {{48{ls64[15]}}, ls64[15:0]};
      3'b010:  ext64 = {{32{ls64[31]}}, ls64[31:0]};
      3'b100:  ext64 = {56'd0, ls64[7:0]};
      3'b101:  ext64 = {48'd0, ls64[15:0]};
      3'b110:  ext64 = {32'd0, ls64[31:0]};
      default: ext64 = ls64;
    endcase
    enq_val = i_lsu_lden ? ext64[CPU_WIDTH-1:0] : i_lsu_exres;
  end

  always_comb begin
    val_d    = val_q;
    rdid_d   = rdid_q;
    pc_d     = pc_q;
    rdwen_d  = rdwen_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    retire_d = retire_q;
    if (push) begin
      val_d[wr_ptr_q]   = enq_val;
      rdid_d[wr_ptr_q]  = i_lsu_rdid;
      pc_d[wr_ptr_q]    = s_lsu_diffpc;
      rdwen_d[wr_ptr_q] = i_lsu_rdwen;
      wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PW'(1);
      retire_d = retire_q + 64'd1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Scan oldest to youngest so the last match wins; the head is included even
  // when it is popping this cycle.
  always_comb begin
    int unsigned p;
    logic [PW-1:0] idx;
    logic live;
    o_rs1_hit = 1'b0;
    o_rs2_hit = 1'b0;
    o_rs1_fwd = '0;
    o_rs2_fwd = '0;
    p    = 0;
    idx  = '0;
    live = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      p = 32'(rd_ptr_q) + i;
      if (p >= DEPTH) p = p - DEPTH;
      idx  = PW'(p);
      live = (i < 32'(count_q)) & rdwen_q[idx] & (rdid_q[idx] != '0);
      if (live && (rdid_q[idx] == i_rs1id)) begin
        o_rs1_hit = 1'b1;
        o_rs1_fwd = val_q[idx];
      end
      if (live && (rdid_q[idx] == i_rs2id)) begin
        o_rs2_hit = 1'b1;
        o_rs2_fwd = val_q[idx];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        val_q[i]  <= '0;
        rdid_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      rdwen_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      retire_q <= '0;
    end else begin
      val_q    <= val_d;
      rdid_q   <= rdid_d;
      pc_q     <= pc_d;
      rdwen_q  <= rdwen_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      retire_q <= retire_d;
    end
  end

endmodule

// File: tb/tb_wbu_buf.sv
// Directed and randomized checks of wbu_buf against a queue-based reference model.
module tb_wbu_buf;

  localparam int unsigned W  = 64;
  localparam int unsigned AW = 5;
  localparam int unsigned D  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          pre_valid, pre_ready;
  logic [W-1:0]  exres, lsres, lpc;
  logic [2:0]    ldfmt;
  logic [AW-1:0] rdid_in;
  logic          rdwen_in, lden;
  logic          wbu_valid, wbu_ready, wbu_rdwen;
  logic [W-1:0]  wbu_rd, wbu_pc;
  logic [AW-1:0] wbu_rdid, rs1, rs2;
  logic          rs1_hit, rs2_hit;
  logic [W-1:0]  rs1_fwd, rs2_fwd;
  logic [63:0]   retire;

  wbu_buf #(.CPU_WIDTH(W), .REG_ADDRW(AW), .DEPTH(D)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_pre_valid(pre_valid), .o_pre_ready(pre_ready),
    .i_lsu_exres(exres), .i_lsu_lsres(lsres), .i_lsu_ldfmt(ldfmt),
    .i_lsu_rdid(rdid_in), .i_lsu_rdwen(rdwen_in), .i_lsu_lden(lden),
    .s_lsu_diffpc(lpc),
    .o_wbu_valid(wbu_valid), .i_wbu_ready(wbu_ready),
    .o_wbu_rdwen(wbu_rdwen), .o_wbu_rd(wbu_rd), .o_wbu_rdid(wbu_rdid),
    .i_rs1id(rs1), .i_rs2id(rs2),
    .o_rs1_hit(rs1_hit), .o_rs2_hit(rs2_hit),
    .o_rs1_fwd(rs1_fwd), .o_rs2_fwd(rs2_fwd),
    .o_retire_cnt(retire), .s_wbu_diffpc(wbu_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]   rd;
    logic [AW-1:0] rdid;
    logic          rdwen;
    logic [63:0]   pc;
  } ent_t;

  ent_t        q[$];
  logic [63:0] m_retire;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [63:0] ext(input logic [63:0] v, input logic [2:0] f);
    logic [63:0] b, h, w;
    b = v & 64'hFF;
    h = v & 64'hFFFF;
    w = v & 64'hFFFF_FFFF;
    case (f)
      3'd0:    return (b >= 64'h80)        ? b - 64'h100         : b;
      3'd1:    return (h >= 64'h8000)      ? h - 64'h1_0000      : h;
      3'd2:    return (w >= 64'h8000_0000) ? w - 64'h1_0000_0000 : w;
      3'd4:    return b;
      3'd5:    return h;
      3'd6:    return w;
      default: return v;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input logic [AW-1:0] id, output logic hit, output logic [63:0] val);
    hit = 1'b0;
    val = '0;
    for (int k = q.size() - 1; k >= 0; k--) begin
      if (q[k].rdwen && q[k].rdid == id && id != 0) begin
        hit = 1'b1;
        val = q[k].rd;
        break;
      end
    end
  endtask

  function automatic logic model_ready();
    return (q.size() < D) || (q.size() > 0 && wbu_ready);
  endfunction

  task automatic check_outputs();
    logic        h;
    logic [63:0] f;
    logic        exp_rdwen;
    chk("pre_ready", 64'(pre_ready), 64'(model_ready()));
    chk("wbu_valid", 64'(wbu_valid), 64'(q.size() > 0));
    exp_rdwen = 1'b0;
    if (q.size() > 0) begin
      chk("head_rd",   wbu_rd,          q[0].rd);
      chk("head_rdid", 64'(wbu_rdid),   64'(q[0].rdid));
      chk("head_pc",   wbu_pc,          q[0].pc);
      exp_rdwen = wbu_ready && q[0].rdwen && q[0].rdid != 0;
    end
    chk("wbu_rdwen", 64'(wbu_rdwen), 64'(exp_rdwen));
    lookup(rs1, h, f);
    chk("rs1_hit", 64'(rs1_hit), 64'(h));
    chk("rs1_fwd", rs1_fwd, f);
    lookup(rs2, h, f);
    chk("rs2_hit", 64'(rs2_hit), 64'(h));
    chk("rs2_fwd", rs2_fwd, f);
    chk("retire", retire, m_retire);
  endtask

  // One clock: check at negedge, then advance the model at the posedge.
  task automatic step();
    logic push, pop;
    ent_t e;
    @(negedge clk);
    check_outputs();
    push = pre_valid && model_ready();
    pop  = (q.size() > 0) && wbu_ready;
    e.rd    = lden ? ext(lsres, ldfmt) : exres;
    e.rdid  = rdid_in;
    e.rdwen = rdwen_in;
    e.pc    = lpc;
    @(posedge clk);
    if (pop) begin
      void'(q.pop_front());
      m_retire++;
    end
    if (push) q.push_back(e);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] ex, input logic [63:0] ls,
                       input logic [2:0] fmt, input logic [AW-1:0] id, input logic we,
                       input logic ld);
    pre_valid = v;
    exres     = ex;
    lsres     = ls;
    ldfmt     = fmt;
    rdid_in   = id;
    rdwen_in  = we;
    lden      = ld;
    lpc       = 64'h8000_0000 + 64'($urandom_range(0, 4095)) * 4;
  endtask

  task automatic do_reset();
    pre_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("rst_valid",  64'(wbu_valid), 64'd0);
    chk("rst_ready",  64'(pre_ready), 64'd1);
    chk("rst_rd",     wbu_rd,         64'd0);
    chk("rst_rdid",   64'(wbu_rdid),  64'd0);
    chk("rst_rdwen",  64'(wbu_rdwen), 64'd0);
    chk("rst_hit",    64'({rs1_hit, rs2_hit}), 64'd0);
    chk("rst_fwd",    rs1_fwd | rs2_fwd, 64'd0);
    chk("rst_retire", retire, 64'd0);
    q.delete();
    m_retire = '0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wbu_ready = 1'b0;
    rs1 = '0;
    rs2 = '0;
    m_retire = '0;
    drive(1'b0, '0, '0, 3'd0, '0, 1'b0, 1'b0);
    #2;
    do_reset();

    // Load extension
    wbu_ready = 1'b0;
    drive(1'b1, 64'h5, 64'h80, 3'b000, 5'd3, 1'b1, 1'b1);
    step();
    chk("ext_sbyte", wbu_rd, 64'hFFFF_FFFF_FFFF_FF80);
    wbu_ready = 1'b1;
    drive(1'b1, 64'h5, 64'h80, 3'b100, 5'd3, 1'b1, 1'b1);
    step();
    chk("ext_zbyte", wbu_rd, 64'h80);
    drive(1'b1, 64'h5, 64'h8000_0000, 3'b110, 5'd3, 1'b1, 1'b1);
    step();
    chk("ext_zword", wbu_rd, 64'h0000_0000_8000_0000);
    pre_valid = 1'b0;
    step();

    // Fill with sink stalled; third push refused
    wbu_ready = 1'b0;
    drive(1'b1, 64'hA, '0, 3'd0, 5'd1, 1'b1, 1'b0);
    step();
    drive(1'b1, 64'hB, '0, 3'd0, 5'd2, 1'b1, 1'b0);
    step();
    chk("full_ready", 64'(pre_ready), 64'd0);
    drive(1'b1, 64'hC, '0, 3'd0, 5'd3, 1'b1, 1'b0);
    step();
    chk("stall_head", wbu_rd, 64'hA);
    step();
    chk("stall_head2", wbu_rd, 64'hA);

    // Simultaneous push and pop while full
    wbu_ready = 1'b1;
    drive(1'b1, 64'hD, '0, 3'd0, 5'd4, 1'b0, 1'b0);
    step();
    chk("pp_head", wbu_rd, 64'hB);
    chk("pp_valid", 64'(wbu_valid), 64'd1);
    pre_valid = 1'b0;
    step();
    step();
    step();

    // Forwarding picks the youngest; rd=0 is never forwarded nor written
    wbu_ready = 1'b0;
    rs1 = 5'd5;
    drive(1'b1, 64'h11, '0, 3'd0, 5'd5, 1'b1, 1'b0);
    step();
    drive(1'b1, 64'h22, '0, 3'd0, 5'd5, 1'b1, 1'b0);
    step();
    chk("fwd_hit", 64'(rs1_hit), 64'd1);
    chk("fwd_young", rs1_fwd, 64'h22);
    pre_valid = 1'b0;
    wbu_ready = 1'b1;
    step();
    step();
    rs1 = 5'd0;
    wbu_ready = 1'b0;
    drive(1'b1, 64'h33, '0, 3'd0, 5'd0, 1'b1, 1'b0);
    step();
    wbu_ready = 1'b1;
    pre_valid = 1'b0;
    #1;
    chk("rd0_rdwen", 64'(wbu_rdwen), 64'd0);
    chk("rd0_hit", 64'(rs1_hit), 64'd0);
    step();

    // Retire counter, then reset with entries buffered
    do_reset();
    wbu_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 64'(k), '0, 3'd0, 5'(k + 1), 1'(k % 2), 1'b0);
      step();
      pre_valid = 1'b0;
      step();
    end
    chk("retire10", retire, 64'd10);
    wbu_ready = 1'b0;
    drive(1'b1, 64'h44, '0, 3'd0, 5'd6, 1'b1, 1'b0);
    step();
    step();
    chk("pre_rst_valid", 64'(wbu_valid), 64'd1);
    #2;
    do_reset();
    drive(1'b1, 64'h55, '0, 3'd0, 5'd7, 1'b1, 1'b0);
    step();
    chk("post_rst_head", wbu_rd, 64'h55);
    pre_valid = 1'b0;
    wbu_ready = 1'b1;
    step();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
            3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      wbu_ready = 1'($urandom_range(0, 2) != 0);
      rs1 = 5'($urandom_range(0, 3));
      rs2 = 5'($urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
